// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, tag field positions and tag-walker state encoding
package dcache_pkg;

    localparam int IDX_W         = 8;
    localparam int TAG_W         = 19;
    localparam int OFS_W         = 5;
    localparam int TAG_RAM_W     = TAG_W + 2;

    localparam int TAG_VALID_BIT = 20;
    localparam int TAG_DIRTY_BIT = 19;
    localparam int TAG_ADDR_MSB  = 18;

    localparam logic [2:0] ST_RST_WALK = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_INV_WALK = 3'd2;
    localparam logic [2:0] ST_RD       = 3'd3;
    localparam logic [2:0] ST_CHK      = 3'd4;
    localparam logic [2:0] ST_EVICT    = 3'd5;
    localparam logic [2:0] ST_WR       = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    typedef enum logic [2:0] {
        S_RST_WALK = ST_RST_WALK,
        S_IDLE     = ST_IDLE,
        S_INV_WALK = ST_INV_WALK,
        S_RD       = ST_RD,
        S_CHK      = ST_CHK,
        S_EVICT    = ST_EVICT,
        S_WR       = ST_WR,
        S_DONE     = ST_DONE
    } walk_state_e;

    // Byte address of the first byte of a cache line.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_core_tag_walker.sv
// rtl/dcache_core_tag_walker.sv - dcache tag RAM maintenance sequencer; DCACHE_FLUSH_STATS_EN adds evict_cnt_o
module dcache_core_tag_walker
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 invalidate_i,
    input  logic                 inv_line_i,
    input  logic [31:0]          inv_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [IDX_W-1:0]     tag_rd_addr_o,
    input  logic [TAG_RAM_W-1:0] tag_rd_data_i,
    output logic                 tag_wr_o,
    output logic [IDX_W-1:0]     tag_wr_addr_o,
    output logic [TAG_RAM_W-1:0] tag_wr_data_o,
    output logic                 evict_valid_o,
    output logic [31:0]          evict_addr_o,
    input  logic                 evict_accept_i
`ifdef DCACHE_FLUSH_STATS_EN
    ,
    output logic [8:0]           evict_cnt_o
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    walk_state_e      state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             line_mode, line_mode_d;
    logic [TAG_W-1:0] inv_tag, inv_tag_d;
    logic [TAG_W-1:0] evict_tag, evict_tag_d;

    logic             rd_valid;
    logic             rd_dirty;
    logic [TAG_W-1:0] rd_tag;
    logic             unused_ofs;

    assign rd_valid   = tag_rd_data_i[TAG_VALID_BIT];
    assign rd_dirty   = tag_rd_data_i[TAG_DIRTY_BIT];
    assign rd_tag     = tag_rd_data_i[TAG_ADDR_MSB:0];
    assign unused_ofs = ^inv_addr_i[OFS_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RST_WALK;
            idx       <= '0;
            line_mode <= 1'b0;
            inv_tag   <= '0;
            evict_tag <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            line_mode <= line_mode_d;
            inv_tag   <= inv_tag_d;
            evict_tag <= evict_tag_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        line_mode_d = line_mode;
        inv_tag_d   = inv_tag;
        evict_tag_d = evict_tag;
        case (state)
            S_RST_WALK, S_INV_WALK: begin
                idx_d = idx + IDX_W'(1);
                if (idx == IDX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_IDLE: begin
                if (flush_i) begin
                    line_mode_d = 1'b0;
                    idx_d       = '0;
                    state_d     = S_RD;
                end else if (invalidate_i) begin
                    idx_d   = '0;
                    state_d = S_INV_WALK;
                end else if (inv_line_i) begin
                    line_mode_d = 1'b1;
                    idx_d       = inv_addr_i[OFS_W+IDX_W-1:OFS_W];
                    inv_tag_d   = inv_addr_i[31:32-TAG_W];
                    state_d     = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                // Single-line invalidate drops dirty data on purpose: no writeback.
                if (line_mode) begin
                    state_d = (rd_valid && rd_tag == inv_tag) ? S_WR : S_DONE;
                end else if (rd_valid && rd_dirty) begin
                    evict_tag_d = rd_tag;
                    state_d     = S_EVICT;
                end else begin
                    state_d = S_WR;
                end
            end
            S_EVICT: begin
                if (evict_accept_i) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (line_mode) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = (idx == IDX_LAST) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RST_WALK;
                idx_d   = '0;
            end
        endcase
    end

    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);
    assign tag_rd_addr_o = idx;
    assign tag_wr_addr_o = idx;
    assign tag_wr_data_o = '0;
    assign tag_wr_o      = (state == S_RST_WALK) || (state == S_INV_WALK) || (state == S_WR);
    assign evict_valid_o = (state == S_EVICT);
    assign evict_addr_o  = line_addr(evict_tag, idx);

`ifdef DCACHE_FLUSH_STATS_EN
    logic [8:0] evict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            evict_cnt <= '0;
        end else if (state == S_IDLE && flush_i) begin
            evict_cnt <= '0;
        end else if (state == S_EVICT && evict_accept_i && evict_cnt != 9'd256) begin
            evict_cnt <= evict_cnt + 9'd1;
        end
    end

    assign evict_cnt_o = evict_cnt;
`endif

endmodule

// File: tb/tb_dcache_core_tag_walker.sv
// tb/tb_dcache_core_tag_walker.sv - scoreboard bench for dcache_core_tag_walker with a tag RAM model
module tb_dcache_core_tag_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        invalidate_i = 1'b0;
    logic        inv_line_i = 1'b0;
    logic [31:0] inv_addr_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  tag_rd_addr_o;
    logic [20:0] tag_rd_data_i;
    logic        tag_wr_o;
    logic [7:0]  tag_wr_addr_o;
    logic [20:0] tag_wr_data_o;
    logic        evict_valid_o;
    logic [31:0] evict_addr_o;
    logic        evict_accept_i = 1'b0;
`ifdef DCACHE_FLUSH_STATS_EN
    logic [8:0]  evict_cnt_o;
`endif

    dcache_core_tag_walker dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .invalidate_i   (invalidate_i),
        .inv_line_i     (inv_line_i),
        .inv_addr_i     (inv_addr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .tag_rd_addr_o  (tag_rd_addr_o),
        .tag_rd_data_i  (tag_rd_data_i),
        .tag_wr_o       (tag_wr_o),
        .tag_wr_addr_o  (tag_wr_addr_o),
        .tag_wr_data_o  (tag_wr_data_o),
        .evict_valid_o  (evict_valid_o),
        .evict_addr_o   (evict_addr_o),
        .evict_accept_i (evict_accept_i)
`ifdef DCACHE_FLUSH_STATS_EN
        ,
        .evict_cnt_o    (evict_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Tag RAM: registered read, write-first; bench preload port used only while the DUT is idle.
    logic [20:0] mem [256];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_addr = '0;
    logic [20:0] bk_data = '0;
    logic        ram_we;
    logic [7:0]  ram_wa;
    logic [20:0] ram_wd;

    assign ram_we = tag_wr_o | bk_we;
    assign ram_wa = tag_wr_o ? tag_wr_addr_o : bk_addr;
    assign ram_wd = tag_wr_o ? tag_wr_data_o : bk_data;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        tag_rd_data_i <= (ram_we && ram_wa == tag_rd_addr_o) ? ram_wd : mem[tag_rd_addr_o];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [20:0]  ref_mem [256];
    logic [31:0]  evq [$];
    int           accepted = 0;
    int           wr_count = 0;
    int           force_stall = 0;
    logic         abandon = 1'b1;

    always @(negedge clk) begin
        if (tag_wr_o === 1'b1) wr_count++;
    end

    // Eviction monitor: drives accept, checks hold-while-stalled and the WR after each accept.
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        wr_expected = 1'b0;
    logic [7:0]  wr_exp_idx = '0;
    int          vcnt = 0;

    always @(negedge clk) begin
        logic acc;
        if (abandon) begin
            prev_pending   = 1'b0;
            wr_expected    = 1'b0;
            vcnt           = 0;
            evict_accept_i = 1'b0;
        end else begin
            if (prev_pending)
                chk("evict_hold", {evict_valid_o, evict_addr_o}, {1'b1, prev_addr});
            if (wr_expected) begin
                chk("wr_after_accept", {tag_wr_o, tag_wr_addr_o}, {1'b1, wr_exp_idx});
                wr_expected = 1'b0;
            end
            if (evict_valid_o === 1'b1) begin
                vcnt++;
                if (force_stall > 0) acc = (vcnt > force_stall);
                else                 acc = 1'($urandom_range(0, 1));
                evict_accept_i = acc;
                if (acc) begin
                    if (evq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL evict_unexpected: got addr %h expected no eviction", evict_addr_o);
                    end else begin
                        chk("evict_addr", evict_addr_o, evq.pop_front());
                    end
                    accepted++;
                    vcnt         = 0;
                    force_stall  = 0;
                    wr_expected  = 1'b1;
                    wr_exp_idx   = evict_addr_o[12:5];
                    prev_pending = 1'b0;
                end else begin
                    prev_pending = 1'b1;
                    prev_addr    = evict_addr_o;
                end
            end else begin
                evict_accept_i = 1'($urandom_range(0, 1));
                prev_pending   = 1'b0;
                vcnt           = 0;
            end
        end
    end

    task automatic bk_write(input logic [7:0] a, input logic [20:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(negedge clk);
        bk_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_walk(input string nm);
        for (int i = 0; i < 256; i++) begin
            chk(nm, {tag_wr_o, tag_wr_addr_o, tag_wr_data_o}, {1'b1, 8'(i), 21'd0});
            @(negedge clk);
        end
        chk({nm, "_done"}, done_o, 1'b1);
        @(negedge clk);
        chk({nm, "_idle"}, {busy_o, done_o}, 2'b00);
    endtask

    task automatic compare_mem(input string nm);
        for (int i = 0; i < 256; i++) chk(nm, {8'(i), mem[i]}, {8'(i), ref_mem[i]});
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        abandon = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        evq.delete();
        force_stall = 0;
        chk({nm, "_state"}, {busy_o, done_o, evict_valid_o}, 3'b100);
        check_walk(nm);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        abandon = 1'b0;
    endtask

    task automatic pulse(input int kind, input logic [31:0] a);
        @(negedge clk);
        flush_i = (kind == 0); invalidate_i = (kind == 1); inv_line_i = (kind == 2);
        inv_addr_i = a;
        @(negedge clk);
        flush_i = 1'b0; invalidate_i = 1'b0; inv_line_i = 1'b0;
        inv_addr_i = $urandom;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int cyc = 1;
        while (done_o !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, done_o, 1'b1);
        @(negedge clk);
        chk({nm, "_idle"}, {busy_o, done_o}, 2'b00);
    endtask

    function automatic void model_flush();
        for (int i = 0; i < 256; i++) begin
            if (ref_mem[i][20] && ref_mem[i][19]) evq.push_back({ref_mem[i][18:0], 8'(i), 5'b0});
            ref_mem[i] = '0;
        end
    endfunction

    task automatic run_flush(input string nm, input int stall);
        int exp_n = evq.size();
        int base  = accepted;
        force_stall = stall;
        pulse(0, '0);
        wait_done(nm, 20000);
        chk({nm, "_leftover"}, evq.size(), 0);
        chk({nm, "_evicts"}, accepted - base, exp_n);
        compare_mem({nm, "_mem"});
    endtask

    task automatic run_inv_line(input string nm, input logic [31:0] a);
        logic [7:0] ix = a[12:5];
        int         expw = (ref_mem[ix][20] && ref_mem[ix][18:0] == a[31:13]) ? 1 : 0;
        int         w0 = wr_count;
        if (expw != 0) ref_mem[ix] = '0;
        pulse(2, a);
        wait_done(nm, 50);
        chk({nm, "_writes"}, wr_count - w0, expw);
        chk({nm, "_entry"}, mem[ix], ref_mem[ix]);
    endtask

    initial begin
        int w0;
        int cyc;
        logic [7:0]  ix;
        logic [31:0] a;

        do_reset("rst_walk");

        // Directed flush: two dirty-valid lines, plus a clean line and a dirty-but-invalid line.
        bk_write(8'd3,   {2'b11, 19'h01234});
        bk_write(8'd200, {2'b11, 19'h01234});
        bk_write(8'd50,  {2'b10, 19'h00abc});
        bk_write(8'd77,  {2'b01, 19'h7ffff});
        evq.push_back(32'h02468060);
        evq.push_back(32'h02469900);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        run_flush("flush_dir", 5);
`ifdef DCACHE_FLUSH_STATS_EN
        chk("evict_cnt", evict_cnt_o, 9'd2);
`endif

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 40; k++) bk_write(8'($urandom_range(0, 255)), 21'($urandom));
            model_flush();
            run_flush("flush_rand", 0);
        end

        bk_write(8'd3, {2'b11, 19'h01234});
        run_inv_line("inv_line_hit", 32'h02468060);
        bk_write(8'd3, {2'b11, 19'h01234});
        run_inv_line("inv_line_miss", 32'h02470060);
        for (int r = 0; r < 8; r++) begin
            ix = 8'($urandom_range(0, 255));
            bk_write(ix, 21'($urandom));
            a = $urandom;
            if (r % 2 == 0) a = {ref_mem[ix][18:0], ix, 5'($urandom)};
            else            a[12:5] = ix;
            run_inv_line("inv_line_rand", a);
        end

        for (int k = 0; k < 30; k++) bk_write(8'($urandom_range(0, 255)), {2'b11, 19'($urandom)});
        w0 = wr_count;
        cyc = accepted;
        pulse(1, '0);
        check_walk("inv_all");
        chk("inv_all_writes", wr_count - w0, 256);
        chk("inv_all_evicts", accepted - cyc, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        compare_mem("inv_all_mem");

        // Reset while stalled in EVICT at idx 100.
        bk_write(8'd100, {2'b11, 19'h05a5a});
        bk_write(8'd20,  {2'b10, 19'h00111});
        model_flush();
        force_stall = 1000000;
        pulse(0, '0);
        cyc = 0;
        while (!(evict_valid_o === 1'b1 && evict_addr_o[12:5] == 8'd100) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_evict100", {evict_valid_o, evict_addr_o}, {1'b1, 32'h0b4b4c80});
        repeat (3) @(negedge clk);
        chk("evict100_held", {evict_valid_o, evict_addr_o}, {1'b1, 32'h0b4b4c80});
        do_reset("rst_mid_evict");
        compare_mem("rst_mid_mem");

        for (int k = 0; k < 20; k++) bk_write(8'($urandom_range(0, 255)), 21'($urandom));
        model_flush();
        run_flush("flush_after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
